issue_scoreboard: RTL and testbench
===================================

# issue_scoreboard

Register-dependence interlock between decode and execute in the x86-64 micro-instruction pipeline. For each micro-instruction offered at issue, it checks the register-usage flags produced by the register usage table against a busy-bit scoreboard for general registers, floating-point registers and EFLAGS. It stalls issue on read-after-write and write-after-write hazards and on outstanding-operation overflow. Busy bits are released when the writeback port retires a result.

## Interface
Parameters:
- REG_ADDR_W, 5: register index width; each register file has 2**REG_ADDR_W entries.
- MAX_INFLIGHT, 4: maximum number of accepted, not-yet-retired writing micro-instructions (1..15).

Ports:
- clk  in  1  pipeline clock.
- rstn  in  1  reset; asynchronous, active-low.
- flush  in  1  synchronous; clears all scoreboard state.
- issue_valid  in  1  decode offers a micro-instruction.
- issue_ready  out  1  scoreboard accepts it this cycle.
- from_gd, from_fd, to_gd, to_fd, from_gs, from_fs, from_gt, from_ft, from_ef, to_ef  in  1 each  usage flags from the register usage table.
- d, s, t  in  REG_ADDR_W each  register indices.
- wb_valid  in  1  one micro-instruction retires this cycle.
- wb_gd, wb_fd, wb_ef  in  1 each  which destinations it writes.
- wb_d  in  REG_ADDR_W  destination index.
- inflight  out  $clog2(MAX_INFLIGHT+1)  current outstanding count.
- sb_err  out  1  sticky protocol-error flag.

## Operation
- State: gbusy[2**REG_ADDR_W], fbusy[2**REG_ADDR_W], efbusy, inflight counter, sb_err.
- An instruction is a writer when to_gd|to_fd|to_ef.
- Hazard. Each term is qualified by its flag:
  - from_gd & gbusy[d]; from_gs & gbusy[s]; from_gt & gbusy[t]
  - from_fd & fbusy[d]; from_fs & fbusy[s]; from_ft & fbusy[t]
  - from_ef & efbusy
  - WAW: to_gd & gbusy[d]; to_fd & fbusy[d]; to_ef & efbusy
- issue_ready = ~flush & ~hazard & ~(writer & inflight==MAX_INFLIGHT & ~wb_valid).
  - A retirement in the same cycle frees a slot.
- issue_ready is combinational and independent of issue_valid.
- Accept = issue_valid & issue_ready. On accept, set gbusy[d] if to_gd, fbusy[d] if to_fd, efbusy if to_ef.
- On wb_valid:
  - Clear gbusy[wb_d] if wb_gd, fbusy[wb_d] if wb_fd, efbusy if wb_ef.
  - Decrement inflight, unless it is already 0.
- inflight_next = inflight + (accept & writer) − wb_valid. Simultaneous accept and retire leaves inflight unchanged.
- Same-cycle set and clear of the same bit: the set wins, so the bit stays busy.
- Non-writers (NOP, J, JR, Jcc, CMP issued with to_ef=0) never change state when accepted.
- sb_err is set, and stays set until reset, on any of:
  - wb_valid with inflight==0;
  - wb_gd to a register whose gbusy bit is clear;
  - wb_fd to a register whose fbusy bit is clear;
  - wb_ef while efbusy is clear.
- Erroneous retirements still apply their clears. The counter saturates at 0.
- flush: all busy bits and inflight go to 0 at the next edge. Issue and wb that cycle are ignored; issue_ready=0. sb_err is unaffected.

## Timing
- Reset (rstn low, asynchronous): all busy bits 0, inflight=0, sb_err=0. issue_ready is then 1 whenever flush=0.
- State updates on the rising clk edge after accept or wb. A dependent instruction sees busy set in the cycle after its producer is accepted.
- Without forwarding, a consumer stalled on register R becomes ready in the cycle after the wb of R.
- Reset deasserting mid-stall: the stalled instruction is immediately ready because the scoreboard is empty.

## Configuration
- SCOREBOARD_FWD_EN defined:
  - A hazard term on register R (or EFLAGS) is suppressed when the same-cycle wb clears R.
  - The consumer issues in the wb cycle.
  - A WAW on R is also allowed that cycle; the new set wins, so R stays busy.
- Undefined: same-cycle wb does not suppress hazards, so the consumer issues one cycle later.

## Test plan
- ADD d=3 accepted at cycle 0; ADD with gs, s=3 offered at cycle 1 → issue_ready=0. wb_gd, wb_d=3 at cycle 4 → ready at cycle 4 with FWD_EN, cycle 5 without.
- CMP (to_ef) accepted, then JE (from_ef) → stalled until wb_ef. A MOVI d=7 offered while JE stalls has issue_ready=1 when presented alone.
- MAX_INFLIGHT=4: four writers accepted to d=1..4; fifth writer to d=5 → not ready. With wb_valid in the same cycle → ready, inflight stays 4.
- Same cycle: accept to_gd d=9 while wb_gd d=9 (FWD_EN) → gbusy[9]=1 afterwards, inflight unchanged.
- wb_valid with inflight=0 → sb_err=1 and held; inflight stays 0.
- Busy state on g2, f5 and ef, then flush=1 for one cycle → all clear, issue_ready=0 during flush, 1 afterwards; async rstn pulse mid-cycle clears inflight immediately.

Source files
------------

// File: rtl/issue_scoreboard.sv
// Register-dependence interlock between decode and execute: busy-bit scoreboard
// for GPRs, FPRs and EFLAGS. Define SCOREBOARD_FWD_EN to let a same-cycle writeback clear hazards.
module issue_scoreboard #(
  parameter int REG_ADDR_W   = 5,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              flush,
  input  logic                              issue_valid,
  output logic                              issue_ready,
  input  logic                              from_gd,
  input  logic                              from_fd,
  input  logic                              to_gd,
  input  logic                              to_fd,
  input  logic                              from_gs,
  input  logic                              from_fs,
  input  logic                              from_gt,
  input  logic                              from_ft,
  input  logic                              from_ef,
  input  logic                              to_ef,
  input  logic [REG_ADDR_W-1:0]             d,
  input  logic [REG_ADDR_W-1:0]             s,
  input  logic [REG_ADDR_W-1:0]             t,
  input  logic                              wb_valid,
  input  logic                              wb_gd,
  input  logic                              wb_fd,
  input  logic                              wb_ef,
  input  logic [REG_ADDR_W-1:0]             wb_d,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic                              sb_err
);

  localparam int NREG  = 2 ** REG_ADDR_W;
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  logic [NREG-1:0]  gbusy_q, gbusy_d, fbusy_q, fbusy_d;
  logic             efbusy_q, efbusy_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic             sb_err_q, sb_err_d;

  logic [NREG-1:0]  gclr, fclr, gset, fset, gvis, fvis;
  logic             efclr, efvis;
  logic             writer, hazard, full, accept, wb_err;

  // Clear and set masks; the set mask is applied last so a same-cycle set wins.
  // NOTE: combinational blocks use blocking '=' and give every target a default
  // first, so no path through the block can leave a latch behind.
  always_comb begin
    gclr = '0;
    fclr = '0;
    gset = '0;
    fset = '0;
    if (wb_valid && wb_gd) gclr[wb_d] = 1'b1;
    if (wb_valid && wb_fd) fclr[wb_d] = 1'b1;
    if (accept && to_gd)   gset[d]    = 1'b1;
    if (accept && to_fd)   fset[d]    = 1'b1;
  end
  assign efclr = wb_valid & wb_ef;

`ifdef SCOREBOARD_FWD_EN
  assign gvis  = gbusy_q & ~gclr;
  assign fvis  = fbusy_q & ~fclr;
  assign efvis = efbusy_q & ~efclr;
`else
  assign gvis  = gbusy_q;
  assign fvis  = fbusy_q;
  assign efvis = efbusy_q;
`endif

  assign writer = to_gd | to_fd | to_ef;

  assign hazard = (from_gd & gvis[d]) | (from_gs & gvis[s]) | (from_gt & gvis[t])
                | (from_fd & fvis[d]) | (from_fs & fvis[s]) | (from_ft & fvis[t])
                | (from_ef & efvis)
                | (to_gd & gvis[d]) | (to_fd & fvis[d]) | (to_ef & efvis);

  // A retirement in the same cycle frees a slot for a new writer.
  assign full        = (inflight_q == CNT_W'(MAX_INFLIGHT));
  assign issue_ready = ~flush & ~hazard & ~(writer & full & ~wb_valid);
  assign accept      = issue_valid & issue_ready;

  assign wb_err = wb_valid & ((inflight_q == '0)
                            | (wb_gd & ~gbusy_q[wb_d])
                            | (wb_fd & ~fbusy_q[wb_d])
                            | (wb_ef & ~efbusy_q));

  always_comb begin
    gbusy_d    = (gbusy_q & ~gclr) | gset;
    fbusy_d    = (fbusy_q & ~fclr) | fset;
    efbusy_d   = (efbusy_q & ~efclr) | (accept & to_ef);
    inflight_d = inflight_q + CNT_W'(accept & writer)
                            - CNT_W'(wb_valid & (inflight_q != '0));
    sb_err_d   = sb_err_q | wb_err;
    if (flush) begin
      gbusy_d    = '0;
      fbusy_d    = '0;
      efbusy_d   = 1'b0;
      inflight_d = '0;
      sb_err_d   = sb_err_q;
    end
  end

  // NOTE: the busy arrays are flop vectors, not RAM, and must be reset: an
  // unknown busy bit would stall or let through instructions arbitrarily.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gbusy_q    <= '0;
      fbusy_q    <= '0;
      efbusy_q   <= 1'b0;
      inflight_q <= '0;
      sb_err_q   <= 1'b0;
    end else begin
      gbusy_q    <= gbusy_d;
      fbusy_q    <= fbusy_d;
      efbusy_q   <= efbusy_d;
      inflight_q <= inflight_d;
      sb_err_q   <= sb_err_d;
    end
  end

  assign inflight = inflight_q;
  assign sb_err   = sb_err_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard; inputs change on the falling edge and
// outputs are sampled 1 ns later, well before the next rising edge.
module tb_issue_scoreboard;

`ifdef SCOREBOARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn, flush, issue_valid, issue_ready;
  logic       from_gd, from_fd, to_gd, to_fd, from_gs, from_fs, from_gt, from_ft, from_ef, to_ef;
  logic [4:0] d, s, t, wb_d;
  logic       wb_valid, wb_gd, wb_fd, wb_ef;
  logic [2:0] inflight;
  logic       sb_err;

  int n_vec = 0;
  int n_err = 0;

  issue_scoreboard #(.REG_ADDR_W(5), .MAX_INFLIGHT(4)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .from_gd(from_gd), .from_fd(from_fd), .to_gd(to_gd), .to_fd(to_fd),
    .from_gs(from_gs), .from_fs(from_fs), .from_gt(from_gt), .from_ft(from_ft),
    .from_ef(from_ef), .to_ef(to_ef),
    .d(d), .s(s), .t(t),
    .wb_valid(wb_valid), .wb_gd(wb_gd), .wb_fd(wb_fd), .wb_ef(wb_ef), .wb_d(wb_d),
    .inflight(inflight), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    flush = 0; issue_valid = 0;
    from_gd = 0; from_fd = 0; to_gd = 0; to_fd = 0; from_gs = 0; from_fs = 0;
    from_gt = 0; from_ft = 0; from_ef = 0; to_ef = 0;
    d = 0; s = 0; t = 0;
    wb_valid = 0; wb_gd = 0; wb_fd = 0; wb_ef = 0; wb_d = 0;
  endtask

  task automatic nxt();
    @(negedge clk);
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rstn = 0;
    idle();
    repeat (2) @(negedge clk);
    rstn = 1;
    #1;
    check("rst_ready", issue_ready, 1);
    check("rst_inflight", inflight, 0);
    check("rst_sb_err", sb_err, 0);

    // RAW on g3, released by writeback at cycle 4
    nxt(); issue_valid = 1; to_gd = 1; d = 3; #1 check("add_d3_ready", issue_ready, 1);
    nxt(); issue_valid = 1; from_gs = 1; s = 3; #1 check("raw_g3_stall", issue_ready, 0);
    check("raw_g3_inflight", inflight, 1);
    repeat (2) begin
      nxt(); issue_valid = 1; from_gs = 1; s = 3; #1 check("raw_g3_hold", issue_ready, 0);
    end
    nxt(); issue_valid = 1; from_gs = 1; s = 3; wb_valid = 1; wb_gd = 1; wb_d = 3;
    #1 check("raw_g3_wb_cycle", issue_ready, FWD);
    nxt(); issue_valid = 1; from_gs = 1; s = 3; #1 check("raw_g3_after_wb", issue_ready, 1);
    check("raw_g3_inflight_end", inflight, 0);

    // CMP -> JE on EFLAGS, independent MOVI slips past
    nxt(); issue_valid = 1; to_ef = 1; #1 check("cmp_ready", issue_ready, 1);
    nxt(); issue_valid = 1; from_ef = 1; #1 check("je_stall", issue_ready, 0);
    nxt(); issue_valid = 1; to_gd = 1; d = 7; #1 check("movi_ready", issue_ready, 1);
    nxt(); issue_valid = 1; from_ef = 1; #1 check("je_stall2", issue_ready, 0);
    check("je_inflight", inflight, 2);
    nxt(); issue_valid = 1; from_ef = 1; wb_valid = 1; wb_ef = 1;
    #1 check("je_wb_cycle", issue_ready, FWD);
    nxt(); issue_valid = 1; from_ef = 1; #1 check("je_after_wb", issue_ready, 1);
    check("je_inflight_end", inflight, 1);
    nxt(); wb_valid = 1; wb_gd = 1; wb_d = 7;
    nxt(); #1 check("movi_retired", inflight, 0);
    check("s2_sb_err", sb_err, 0);

    // inflight limit
    for (int i = 1; i <= 4; i++) begin
      nxt(); issue_valid = 1; to_gd = 1; d = 5'(i); #1 check("fill_ready", issue_ready, 1);
    end
    nxt(); issue_valid = 1; to_gd = 1; d = 5; #1 check("full_stall", issue_ready, 0);
    check("full_inflight", inflight, 4);
    nxt(); issue_valid = 1; to_gd = 1; d = 5; wb_valid = 1; wb_gd = 1; wb_d = 1;
    #1 check("full_with_wb", issue_ready, 1);
    nxt(); from_gs = 1; s = 1; #1 check("g1_released", issue_ready, 1);
    s = 5; #1 check("g5_busy", issue_ready, 0);
    check("full_inflight_kept", inflight, 4);
    for (int r = 2; r <= 5; r++) begin
      nxt(); wb_valid = 1; wb_gd = 1; wb_d = 5'(r);
    end
    nxt(); #1 check("drain_inflight", inflight, 0);
    check("drain_sb_err", sb_err, 0);

    // same-cycle set and clear of g9
    nxt(); issue_valid = 1; to_gd = 1; d = 9; #1 check("g9_first", issue_ready, 1);
    nxt(); issue_valid = 1; to_gd = 1; d = 9; wb_valid = 1; wb_gd = 1; wb_d = 9;
    #1 check("g9_waw_wb", issue_ready, FWD);
    nxt(); from_gs = 1; s = 9; #1 check("g9_after", issue_ready, !FWD);
    check("g9_inflight", inflight, FWD ? 1 : 0);
    if (FWD) begin
      nxt(); wb_valid = 1; wb_gd = 1; wb_d = 9;
    end
    nxt(); #1 check("g9_drain", inflight, 0);

    // flush clears g2, f5, ef
    nxt(); issue_valid = 1; to_gd = 1; d = 2;
    nxt(); issue_valid = 1; to_fd = 1; d = 5;
    nxt(); issue_valid = 1; to_ef = 1;
    nxt(); from_fs = 1; s = 5; #1 check("f5_stall", issue_ready, 0);
    check("pre_flush_inflight", inflight, 3);
    nxt(); flush = 1; issue_valid = 1; to_gd = 1; d = 20; wb_valid = 1; wb_gd = 1; wb_d = 2;
    #1 check("flush_ready", issue_ready, 0);
    nxt(); #1 check("post_flush_inflight", inflight, 0);
    from_gd = 1; d = 2; from_fs = 1; s = 5; from_ef = 1;
    #1 check("post_flush_ready", issue_ready, 1);
    idle(); from_gd = 1; d = 20; #1 check("flush_issue_ignored", issue_ready, 1);
    check("post_flush_sb_err", sb_err, 0);

    // protocol errors
    nxt(); wb_valid = 1;
    nxt(); #1 check("err_underflow", sb_err, 1);
    check("err_inflight_sat", inflight, 0);
    nxt(); #1 check("err_sticky", sb_err, 1);
    nxt(); flush = 1;
    nxt(); #1 check("err_survives_flush", sb_err, 1);
    nxt(); rstn = 0; #1 check("err_reset", sb_err, 0);
    rstn = 1;
    nxt(); issue_valid = 1; to_gd = 1; d = 2;
    nxt(); wb_valid = 1; wb_gd = 1; wb_d = 6;
    nxt(); #1 check("err_gbusy_clear", sb_err, 1);
    check("err_gbusy_inflight", inflight, 0);
    from_gs = 1; s = 2; #1 check("g2_still_busy", issue_ready, 0);

    // async reset mid-cycle while a reader stalls
    nxt(); issue_valid = 1; to_fd = 1; d = 1;
    nxt(); issue_valid = 1; from_gs = 1; s = 2;
    #1 check("stall_before_rst", issue_ready, 0);
    check("inflight_before_rst", inflight, 1);
    #1 rstn = 0;
    #1 check("async_rst_inflight", inflight, 0);
    check("async_rst_sb_err", sb_err, 0);
    rstn = 1;
    #1 check("ready_after_rst", issue_ready, 1);

    nxt();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
